// File: rtl/vga_uart_renderer_top.sv
// Board top: a UART byte pair sets an RGB565 colour, VGA 640x480@60 draws a 32x32 checkerboard of it
// and its inverse, and a 4-digit seven-segment display scans the colour in hex.
module vga_uart_renderer_top #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          PIX_DIV      = 2,
    parameter int          SEG_DIV      = 50000,
    parameter logic [15:0] RESET_COLOR  = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RXD,
    output logic       DS_EN1,
    output logic       DS_EN2,
    output logic       DS_EN3,
    output logic       DS_EN4,
    output logic       DS_A,
    output logic       DS_B,
    output logic       DS_C,
    output logic       DS_D,
    output logic       DS_E,
    output logic       DS_F,
    output logic       DS_G,
    output logic       H_SYNC,
    output logic       V_SYNC,
    output logic [4:0] V_R,
    output logic [5:0] V_G,
    output logic [4:0] V_B
);
    localparam int PW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int SW = (SEG_DIV > 1) ? $clog2(SEG_DIV) : 1;
    localparam logic [PW-1:0] PIX_LAST  = PW'(PIX_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [SW-1:0] SEG_LAST  = SW'(SEG_DIV - 1);

    // ---------------- VGA timing ----------------
    logic [PW-1:0] pix_cnt_reg;
    logic [9:0]    h_reg, v_reg;
    logic          pix_en;
    logic [15:0]   color_reg;
    logic          active;
    logic [15:0]   pix_color;

    assign pix_en = (pix_cnt_reg == PIX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt_reg <= '0;
            h_reg       <= '0;
            v_reg       <= '0;
        end else begin
            pix_cnt_reg <= pix_en ? '0 : pix_cnt_reg + PW'(1);
            if (pix_en) begin
                if (h_reg == 10'd799) begin
                    h_reg <= '0;
                    v_reg <= (v_reg == 10'd524) ? 10'd0 : v_reg + 10'd1;
                end else begin
                    h_reg <= h_reg + 10'd1;
                end
            end
        end
    end

    always_comb begin
        active    = (h_reg < 10'd640) && (v_reg < 10'd480);
        pix_color = (h_reg[5] ^ v_reg[5]) ? ~color_reg : color_reg;
    end

    // Syncs and RGB are registered together so they stay aligned one clk behind the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            H_SYNC <= 1'b1;
            V_SYNC <= 1'b1;
            V_R    <= '0;
            V_G    <= '0;
            V_B    <= '0;
        end else begin
            H_SYNC <= !((h_reg >= 10'd656) && (h_reg <= 10'd751));
            V_SYNC <= !((v_reg >= 10'd490) && (v_reg <= 10'd491));
            V_R    <= active ? pix_color[15:11] : 5'd0;
            V_G    <= active ? pix_color[10:5]  : 6'd0;
            V_B    <= active ? pix_color[4:0]   : 5'd0;
        end
    end

    // ---------------- UART receiver ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    rx_state_t     rx_state_reg;
    logic          rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic [BW-1:0] tick_cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;
    logic          byte_valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg    <= 1'b1;
            rx_sync_reg    <= 1'b1;
            rx_prev_reg    <= 1'b1;
            rx_state_reg   <= RX_IDLE;
            tick_cnt_reg   <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            byte_valid_reg <= 1'b0;
        end else begin
            rx_meta_reg    <= RXD;
            rx_sync_reg    <= rx_meta_reg;
            rx_prev_reg    <= rx_sync_reg;
            byte_valid_reg <= 1'b0;
            case (rx_state_reg)
                RX_IDLE: begin
                    tick_cnt_reg <= '0;
                    if (rx_prev_reg && !rx_sync_reg) rx_state_reg <= RX_START;
                end
                RX_START: begin
                    if (tick_cnt_reg == HALF_LAST) begin
                        tick_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                        rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
                    end else begin
                        tick_cnt_reg <= tick_cnt_reg + BW'(1);
                    end
                end
                RX_DATA: begin
                    if (tick_cnt_reg == BIT_LAST) begin
                        tick_cnt_reg <= '0;
                        shift_reg    <= {rx_sync_reg, shift_reg[7:1]};
                        bit_idx_reg  <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7) rx_state_reg <= RX_STOP;
                    end else begin
                        tick_cnt_reg <= tick_cnt_reg + BW'(1);
                    end
                end
                RX_STOP: begin
                    if (tick_cnt_reg == BIT_LAST) begin
                        tick_cnt_reg   <= '0;
                        byte_valid_reg <= rx_sync_reg;
                        rx_state_reg   <= RX_IDLE;
                    end else begin
                        tick_cnt_reg <= tick_cnt_reg + BW'(1);
                    end
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end

    // ---------------- Colour register ----------------
    logic       phase_reg;
    logic [7:0] high_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg <= 1'b0;
            high_reg  <= '0;
            color_reg <= RESET_COLOR;
        end else if (byte_valid_reg) begin
            if (!phase_reg) begin
                high_reg  <= shift_reg;
                phase_reg <= 1'b1;
            end else begin
                color_reg <= {high_reg, shift_reg};
                phase_reg <= 1'b0;
            end
        end
    end

    // ---------------- Seven-segment scan ----------------
    logic [SW-1:0] seg_cnt_reg;
    logic [1:0]    digit_reg;
    logic [3:0]    nibble;
    logic [3:0]    en_next;
    logic [3:0]    en_reg;
    logic [6:0]    seg_reg;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'b0000001;
            4'h1: hex_glyph = 7'b1001111;
            4'h2: hex_glyph = 7'b0010010;
            4'h3: hex_glyph = 7'b0000110;
            4'h4: hex_glyph = 7'b1001100;
            4'h5: hex_glyph = 7'b0100100;
            4'h6: hex_glyph = 7'b0100000;
            4'h7: hex_glyph = 7'b0001111;
            4'h8: hex_glyph = 7'b0000000;
            4'h9: hex_glyph = 7'b0000100;
            4'hA: hex_glyph = 7'b0001000;
            4'hB: hex_glyph = 7'b1100000;
            4'hC: hex_glyph = 7'b0110001;
            4'hD: hex_glyph = 7'b1000010;
            4'hE: hex_glyph = 7'b0110000;
            default: hex_glyph = 7'b0111000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_cnt_reg <= '0;
            digit_reg   <= '0;
        end else if (seg_cnt_reg == SEG_LAST) begin
            seg_cnt_reg <= '0;
            digit_reg   <= digit_reg + 2'd1;
        end else begin
            seg_cnt_reg <= seg_cnt_reg + SW'(1);
        end
    end

    always_comb begin
        nibble = color_reg[3:0];
        case (digit_reg)
            2'd0: nibble = color_reg[15:12];
            2'd1: nibble = color_reg[11:8];
            2'd2: nibble = color_reg[7:4];
            default: nibble = color_reg[3:0];
        endcase
    end

    // en_next[3] drives EN1 (most significant digit), en_next[0] drives EN4.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_en
            assign en_next[3-gi] = (digit_reg != 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            en_reg  <= 4'b1111;
            seg_reg <= 7'b1111111;
        end else begin
            en_reg  <= en_next;
            seg_reg <= hex_glyph(nibble);
        end
    end

    assign {DS_EN1, DS_EN2, DS_EN3, DS_EN4} = en_reg;
    assign {DS_A, DS_B, DS_C, DS_D, DS_E, DS_F, DS_G} = seg_reg;
endmodule

// File: tb/tb_vga_uart_renderer_top.sv
// Scoreboard bench: expected colours/glyphs are queued as stimulus is driven and popped when the
// matching pixel or seven-segment digit appears on the outputs.
module tb_vga_uart_renderer_top;
    localparam int CPB = 16;
    localparam int PD  = 2;
    localparam int SD  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       DS_EN1, DS_EN2, DS_EN3, DS_EN4;
    logic       DS_A, DS_B, DS_C, DS_D, DS_E, DS_F, DS_G;
    logic       H_SYNC, V_SYNC;
    logic [4:0] V_R;
    logic [5:0] V_G;
    logic [4:0] V_B;

    vga_uart_renderer_top #(
        .CLKS_PER_BIT(CPB), .PIX_DIV(PD), .SEG_DIV(SD), .RESET_COLOR(16'hFFFF)
    ) dut (
        .clk(clk), .rst(rst), .RXD(rxd),
        .DS_EN1(DS_EN1), .DS_EN2(DS_EN2), .DS_EN3(DS_EN3), .DS_EN4(DS_EN4),
        .DS_A(DS_A), .DS_B(DS_B), .DS_C(DS_C), .DS_D(DS_D), .DS_E(DS_E), .DS_F(DS_F), .DS_G(DS_G),
        .H_SYNC(H_SYNC), .V_SYNC(V_SYNC), .V_R(V_R), .V_G(V_G), .V_B(V_B)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Rising edges since reset release; the output after edge k shows pixel (k-1)/PD.
    int k;
    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    typedef struct {
        string tag;
        int    val;
    } sb_t;
    sb_t sb_q[$];

    logic [6:0] glyph_tbl [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    logic [15:0] model_color;

    function automatic logic [3:0] en_bus();
        return {DS_EN1, DS_EN2, DS_EN3, DS_EN4};
    endfunction

    function automatic logic [6:0] seg_bus();
        return {DS_A, DS_B, DS_C, DS_D, DS_E, DS_F, DS_G};
    endfunction

    task automatic sb_push(input string tag, input int val);
        sb_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic push_digits(input logic [15:0] c);
        for (int d = 0; d < 4; d++) begin
            logic [3:0] nib;
            nib = 4'((c >> (12 - 4 * d)) & 16'hF);
            sb_push("digit", int'(glyph_tbl[nib]));
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk) rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_color(input logic [15:0] c);
        send_byte(c[15:8], 1'b1);
        send_byte(c[7:0], 1'b1);
        model_color = c;
    endtask

    task automatic observe_pixel(input string tag, input int h);
        bit          found;
        int          n, v;
        logic [15:0] col, c;
        bit          act;
        sb_t         e;
        found = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (k >= 1 && (k - 1) % PD == 0 && ((k - 1) / PD) % 800 == h) begin
                found = 1;
                break;
            end
        end
        check({tag, "_found"}, 32'(found), 32'd1);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_underflow"}, 32'd0, 32'd1);
            return;
        end
        e   = sb_q.pop_front();
        col = e.val[15:0];
        n   = (k - 1) / PD;
        v   = (n / 800) % 525;
        c   = (h[5] ^ v[5]) ? ~col : col;
        act = (h < 640) && (v < 480);
        check({tag, "_r"}, 32'(V_R), act ? 32'(c[15:11]) : 32'd0);
        check({tag, "_g"}, 32'(V_G), act ? 32'(c[10:5])  : 32'd0);
        check({tag, "_b"}, 32'(V_B), act ? 32'(c[4:0])   : 32'd0);
    endtask

    task automatic observe_digits(input string tag);
        bit         found;
        logic [3:0] prev_en, exp_en;
        int         bad;
        sb_t        e;
        found   = 0;
        prev_en = en_bus();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (en_bus() == 4'b0111 && prev_en != 4'b0111) begin
                found = 1;
                break;
            end
            prev_en = en_bus();
        end
        check({tag, "_found"}, 32'(found), 32'd1);
        for (int d = 0; d < 4; d++) begin
            exp_en = ~(4'b1000 >> d);
            if (sb_q.size() == 0) begin
                check({tag, "_sb_underflow"}, 32'd0, 32'd1);
                return;
            end
            e = sb_q.pop_front();
            check({tag, "_seg"}, 32'(seg_bus()), 32'(e.val));
            bad = 0;
            for (int j = 0; j < SD; j++) begin
                if (en_bus() !== exp_en) bad++;
                @(negedge clk);
            end
            check({tag, "_en_hold"}, 32'(bad), 32'd0);
        end
    endtask

    task automatic wait_hsync_fall(output int kk, output bit ok);
        logic prev;
        prev = H_SYNC;
        ok   = 0;
        kk   = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (!H_SYNC && prev) begin
                ok = 1;
                kk = k;
                break;
            end
            prev = H_SYNC;
        end
    endtask

    task automatic measure_hsync(input string tag);
        int t1, t2, low;
        bit ok;
        wait_hsync_fall(t1, ok);
        check({tag, "_fall1"}, 32'(ok), 32'd1);
        check({tag, "_pos"}, 32'(((t1 - 1) / PD) % 800), 32'd656);
        check({tag, "_vsync"}, 32'(V_SYNC), 32'd1);
        check({tag, "_blank"}, 32'({V_R, V_G, V_B}), 32'd0);
        low = 0;
        while (H_SYNC == 1'b0 && low < 4000) begin
            low++;
            @(negedge clk);
        end
        check({tag, "_low"}, 32'(low), 32'd192);
        wait_hsync_fall(t2, ok);
        check({tag, "_fall2"}, 32'(ok), 32'd1);
        check({tag, "_period"}, 32'(t2 - t1), 32'd1600);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hs"},  32'(H_SYNC), 32'd1);
        check({tag, "_vs"},  32'(V_SYNC), 32'd1);
        check({tag, "_rgb"}, 32'({V_R, V_G, V_B}), 32'd0);
        check({tag, "_en"},  32'(en_bus()), 32'hF);
        check({tag, "_seg"}, 32'(seg_bus()), 32'h7F);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_color = 16'hFFFF;
        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Release: first output is pixel (0,0) in the reset colour.
        sb_push("px00_reset", int'(model_color));
        rst = 1'b0;
        observe_pixel("px00_reset", 0);
        push_digits(model_color);
        observe_digits("seg_reset");

        measure_hsync("hs_a");
        measure_hsync("hs_b");

        send_color(16'hF800);
        sb_push("red_h0", int'(model_color));
        observe_pixel("red_h0", 0);
        sb_push("red_h32", int'(model_color));
        observe_pixel("red_h32", 32);
        sb_push("red_h639", int'(model_color));
        observe_pixel("red_h639", 639);
        sb_push("red_h640", int'(model_color));
        observe_pixel("red_h640", 640);
        push_digits(model_color);
        observe_digits("seg_f800");

        // A byte with a bad stop bit must not advance the byte phase.
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        model_color = 16'h3456;
        sb_push("c3456_h0", int'(model_color));
        observe_pixel("c3456_h0", 0);
        sb_push("c3456_h64", int'(model_color));
        observe_pixel("c3456_h64", 64);
        push_digits(model_color);
        observe_digits("seg_3456");

        send_color(16'h1234);
        push_digits(model_color);
        observe_digits("seg_1234");

        // One byte then reset mid-line: colour, counters and byte phase all restart.
        send_byte(8'hAB, 1'b1);
        repeat (300) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_mid");
        model_color = 16'hFFFF;
        sb_push("px00_rst2", int'(model_color));
        rst = 1'b0;
        observe_pixel("px00_rst2", 0);
        measure_hsync("hs_rst2");
        send_color(16'h001F);
        sb_push("c001f_h0", int'(model_color));
        observe_pixel("c001f_h0", 0);
        push_digits(model_color);
        observe_digits("seg_001f");

        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
